// File: rtl/acc_bus_pkg.sv
// Shared accelerator-bus constants, request classification and address-range check.
package acc_bus_pkg;

    localparam int ADDR_WIDTH  = 19;
    localparam int DATA_WIDTH  = 256;
    localparam int WSTRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic {
        REQ_READ  = 1'b0,
        REQ_WRITE = 1'b1
    } req_kind_t;

    // An all-zero strobe marks a read; any set lane makes it a write.
    function automatic req_kind_t req_kind(input logic [WSTRB_WIDTH-1:0] wstrb);
        return (|wstrb) ? REQ_WRITE : REQ_READ;
    endfunction

    function automatic logic addr_out_of_range(input logic [ADDR_WIDTH-1:0] addr,
                                               input int mem_aw);
        logic oor;
        oor = 1'b0;
        for (int i = 0; i < ADDR_WIDTH; i++) begin
            if (i >= mem_aw && addr[i]) oor = 1'b1;
        end
        return oor;
    endfunction

endpackage

// File: rtl/acc_resp_rd_pipe.sv
// Fixed-latency read return pipeline: DEPTH stages of valid/data, oldest stage drives the bus.
module acc_resp_rd_pipe #(
    parameter int DATA_WIDTH = 256,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data
);

    logic [DEPTH-1:0]      valid_q;
    logic [DATA_WIDTH-1:0] data_q [DEPTH];

    // NOTE: sequential state uses non-blocking assignments so every stage shifts from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
        end else begin
            valid_q[0] <= in_valid;
            data_q[0]  <= in_data;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                data_q[i]  <= data_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/acc_mem_responder.sv
// Accelerator-bus responder backed by a byte-writable local memory with fixed read latency.
// Optional request statistics are enabled by defining ACC_RESP_STATS_EN.
module acc_mem_responder #(
    parameter int ADDR_WIDTH      = acc_bus_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH      = acc_bus_pkg::DATA_WIDTH,
    parameter int MEM_AW          = 10,
    parameter int READ_LATENCY    = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    acc_valid,
    input  logic [ADDR_WIDTH-1:0]   acc_addr,
    input  logic [DATA_WIDTH-1:0]   acc_wdata,
    input  logic [DATA_WIDTH/8-1:0] acc_wstrb,
    output logic                    acc_ready,
    output logic [DATA_WIDTH-1:0]   acc_rdata,
    output logic                    acc_rvalid,
    input  logic                    err_clr,
    output logic                    err,
`ifdef ACC_RESP_STATS_EN
    output logic [31:0]             stat_rd_cnt,
    output logic [31:0]             stat_wr_cnt,
`endif
    output logic                    busy
);
    import acc_bus_pkg::*;

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int CNT_W  = 4;

    logic                  fire;
    logic                  rd_fire;
    logic                  wr_fire;
    logic                  oor;
    req_kind_t             kind;
    logic [MEM_AW-1:0]     idx;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [CNT_W-1:0]      out_cnt;
    logic [CNT_W-1:0]      out_cnt_next;
    logic [DATA_WIDTH-1:0] mem [2**MEM_AW];

    assign fire    = acc_valid && acc_ready;
    assign kind    = req_kind(acc_wstrb);
    assign oor     = addr_out_of_range(acc_addr, MEM_AW);
    assign rd_fire = fire && (kind == REQ_READ);
    assign wr_fire = fire && (kind == REQ_WRITE);
    assign idx     = acc_addr[MEM_AW-1:0];
    assign rd_word = oor ? '0 : mem[idx];

    // NOTE: the memory array is deliberately not reset; its contents are undefined until written.
    always_ff @(posedge clk) begin
        if (wr_fire && !oor) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (acc_wstrb[i]) mem[idx][8*i +: 8] <= acc_wdata[8*i +: 8];
            end
        end
    end

    acc_resp_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (READ_LATENCY)
    ) u_rd_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (rd_fire),
        .in_data   (rd_word),
        .out_valid (acc_rvalid),
        .out_data  (acc_rdata)
    );

    // NOTE: the default assignment first keeps this combinational block free of latches.
    always_comb begin
        out_cnt_next = out_cnt;
        if (rd_fire && !acc_rvalid)      out_cnt_next = out_cnt + 1'b1;
        else if (!rd_fire && acc_rvalid) out_cnt_next = out_cnt - 1'b1;
    end

    // Ready looks ahead at the post-edge count so the limit is never overshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_cnt   <= '0;
            acc_ready <= 1'b0;
            err       <= 1'b0;
        end else begin
            out_cnt   <= out_cnt_next;
            acc_ready <= (int'(out_cnt_next) < MAX_OUTSTANDING);
            if (fire && oor)  err <= 1'b1;
            else if (err_clr) err <= 1'b0;
        end
    end

    assign busy = (out_cnt != '0);

`ifdef ACC_RESP_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_rd_cnt <= '0;
            stat_wr_cnt <= '0;
        end else begin
            if (rd_fire && stat_rd_cnt != '1) stat_rd_cnt <= stat_rd_cnt + 1'b1;
            if (wr_fire && stat_wr_cnt != '1) stat_wr_cnt <= stat_wr_cnt + 1'b1;
        end
    end
`endif

endmodule
